// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-port RAM arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int DEF_DW        = 8;
  localparam int DEF_AW        = 6;
  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_W       = 4;
endpackage

// File: rtl/ram_sp_core.sv
// Single-port 2**AW x DW storage; write on the edge, read-old-data registered one cycle later.
module ram_sp_core
  import ram_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Array contents deliberately survive reset; only the output register clears.
  always_ff @(posedge clk) begin
    if (en && we) r_mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rdata <= '0;
    else if (en && !we)  r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;
endmodule

// File: rtl/ram_port_arbiter.sv
// Two requesters share one RAM port: combinational grant, read data one cycle later, lock with MAX_BURST fairness.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 always win IDLE ties instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata
);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  state_t               r_state, w_state_nxt;
  logic [BURST_W-1:0]   r_burst, w_burst_nxt;
  logic                 w_g0, w_g1, w_tie0;
  logic                 r_rvalid0, r_rvalid1;
  logic                 w_en, w_we;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_wdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_tie0 = 1'b1;
`else
  logic r_prio1;
  // Pointer names the port that wins the next IDLE tie: always the one just passed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_prio1 <= 1'b0;
    else if (gnt0) r_prio1 <= 1'b1;
    else if (gnt1) r_prio1 <= 1'b0;
  end
  assign w_tie0 = !r_prio1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // An owner that drops req falls through to plain IDLE arbitration in the same cycle.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (r_state == ST_OWN0 && req0) begin
      if (req1 && r_burst >= BURST_MAX) w_g1 = 1'b1;
      else                              w_g0 = 1'b1;
    end else if (r_state == ST_OWN1 && req1) begin
      if (req0 && r_burst >= BURST_MAX) w_g0 = 1'b1;
      else                              w_g1 = 1'b1;
    end else if (req0 && req1) begin
      w_g0 = w_tie0;
      w_g1 = !w_tie0;
    end else begin
      w_g0 = req0;
      w_g1 = req1;
    end
  end

  // Burst count includes the entry grant when the other port is already waiting.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_burst_nxt = '0;
    if (w_g0 && lock0) begin
      w_state_nxt = ST_OWN0;
      if (req1) w_burst_nxt = (r_state == ST_OWN0) ? r_burst + 1'b1 : BURST_W'(1);
    end else if (w_g1 && lock1) begin
      w_state_nxt = ST_OWN1;
      if (req0) w_burst_nxt = (r_state == ST_OWN1) ? r_burst + 1'b1 : BURST_W'(1);
    end
  end

  assign gnt0 = w_g0 & ~rst;
  assign gnt1 = w_g1 & ~rst;

  assign w_en    = gnt0 | gnt1;
  assign w_we    = gnt0 ? we0    : we1;
  assign w_addr  = gnt0 ? addr0  : addr1;
  assign w_wdata = gnt0 ? wdata0 : wdata1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= gnt0 & ~we0;
      r_rvalid1 <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

  ram_sp_core #(.DW(DW), .AW(AW)) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (w_en),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata)
  );

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] mem_m [64];
  int            owner;      // port currently holding the lock, -1 if none
  int            run;        // consecutive owner grants made while the other port waited
  int            prio;       // port that wins the next plain tie
  bit            exp_rv [2];
  logic [DW-1:0] exp_rdata;

  function automatic int pick(bit r0, bit r1);
    bit r [2];
    r[0] = r0;
    r[1] = r1;
    if (owner >= 0 && r[owner]) begin
      if (r[1-owner] && run >= MB) return 1 - owner;
      return owner;
    end
    if (r0 && r1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return prio;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    req0 = 1; req1 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 8'hFF;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got=%b exp=0", gnt1); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_rvalid0 got=%b exp=0", rvalid0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid1 got=%b exp=0", rvalid1); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    tick();
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 6'd3; wdata0 = 8'hA5;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
    tick();
    req0 = 0; we0 = 0; req1 = 1; we1 = 0; addr1 = 6'd3;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rd_gnt1 got=%b exp=1", gnt1); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", rvalid0); end
    tick();
    req1 = 0;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL rd_rvalid1 got=%b exp=1", rvalid1); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
    tick();
    req0 = 1; we0 = 1; addr0 = 6'd10; wdata0 = 8'h3C;
    tick();
    we0 = 0;
    tick();
    req0 = 0; req1 = 1; we1 = 1; addr1 = 6'd10; wdata1 = 8'hC3;
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || rdata !== 8'h3C) begin errors++; $display("FAIL rw_old got=%b/%h exp=1/3c", rvalid0, rdata); end
    tick();
    we1 = 0;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b0 || rdata !== 8'h3C) begin errors++; $display("FAIL rw_hold got=%b/%h exp=0/3c", rvalid1, rdata); end
    tick();
    req1 = 0;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b1 || rdata !== 8'hC3) begin errors++; $display("FAIL rw_new got=%b/%h exp=1/c3", rvalid1, rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    int prev;
    int exp;
    logic [DW-1:0] val;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 6'd3; addr1 = 6'd10;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = k % 2;
`endif
      @(negedge clk);
      checks++; if (gnt0 !== (exp == 0) || gnt1 !== (exp == 1)) begin errors++; $display("FAIL rr_gnt[%0d] got=%b%b exp_port=%0d", k, gnt0, gnt1, exp); end
      if (prev >= 0) begin
        val = (prev == 0) ? 8'hA5 : 8'hC3;
        checks++; if (rvalid0 !== (prev == 0) || rvalid1 !== (prev == 1) || rdata !== val) begin errors++; $display("FAIL rr_rvalid[%0d] got=%b%b/%h exp_port=%0d/%h", k, rvalid0, rvalid1, rdata, prev, val); end
      end
      prev = exp;
      tick();
    end
    idle_inputs();
    val = (prev == 0) ? 8'hA5 : 8'hC3;
    @(negedge clk);
    checks++; if (rvalid0 !== (prev == 0) || rvalid1 !== (prev == 1) || rdata !== val) begin errors++; $display("FAIL rr_last got=%b%b/%h exp_port=%0d/%h", rvalid0, rvalid1, rdata, prev, val); end
    tick();
  endtask

  task automatic test_burst();
    int exp;
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 6'd3;
    req1 = 1; addr1 = 6'd10;
    for (int k = 0; k < MB + 3; k++) begin
      exp = (k == MB) ? 1 : 0;
      @(negedge clk);
      checks++; if (gnt0 !== (exp == 0) || gnt1 !== (exp == 1)) begin errors++; $display("FAIL burst_gnt[%0d] got=%b%b exp_port=%0d", k, gnt0, gnt1, exp); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int exp;
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 6'd3;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL own1_enter got=%b exp=1", gnt1); end
    tick();
    req0 = 1; addr0 = 6'd3;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL own1_hold got=%b%b exp=01", gnt0, gnt1); end
    tick();
    rst = 1;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL midrst_gnt got=%b%b exp=00", gnt0, gnt1); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    @(posedge clk);
    #1;
    rst = 0;
    lock1 = 0;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL postrst_first got=%b%b exp=10", gnt0, gnt1); end
    checks++; if (rvalid1 !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL postrst_discard got=%b/%h exp=0/00", rvalid1, rdata); end
    tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp = 0;
`else
    exp = 1;
`endif
    @(negedge clk);
    checks++; if (gnt0 !== (exp == 0) || gnt1 !== (exp == 1)) begin errors++; $display("FAIL postrst_second got=%b%b exp_port=%0d", gnt0, gnt1, exp); end
    checks++; if (rvalid0 !== 1'b1 || rdata !== 8'hA5) begin errors++; $display("FAIL ram_kept got=%b/%h exp=1/a5", rvalid0, rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit            pq [2];
    bit            pwe [2];
    bit            lk [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            g;
    bit            oreq;
    do_reset();
    for (int a = 0; a < 64; a++) begin
      req0 = 1; we0 = 1; addr0 = AW'(a); wdata0 = DW'($urandom);
      mem_m[a] = wdata0;
      @(negedge clk);
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL fill_gnt[%0d] got=%b exp=1", a, gnt0); end
      tick();
    end
    idle_inputs();
    owner = -1; run = 0; prio = 1;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rdata = '0;
    pq[0] = 0; pq[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pq[p] && $urandom_range(0, 99) < 70) begin
          pq[p]  = 1;
          pwe[p] = $urandom_range(0, 1) == 1;
          pa[p]  = AW'($urandom_range(0, 7));
          pd[p]  = DW'($urandom);
        end
        lk[p] = $urandom_range(0, 99) < 55;
      end
      req0 = pq[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0]; lock0 = lk[0];
      req1 = pq[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1]; lock1 = lk[1];
      @(negedge clk);
      g = pick(pq[0], pq[1]);
      checks++; if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin errors++; $display("FAIL rnd_gnt[%0d] got=%b%b exp_port=%0d", c, gnt0, gnt1, g); end
      checks++; if (rvalid0 !== exp_rv[0] || rvalid1 !== exp_rv[1]) begin errors++; $display("FAIL rnd_rvalid[%0d] got=%b%b exp=%b%b", c, rvalid0, rvalid1, exp_rv[0], exp_rv[1]); end
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", c, rdata, exp_rdata); end
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (g >= 0) begin
        oreq = pq[1-g];
        if (pwe[g]) mem_m[pa[g]] = pd[g];
        else begin
          exp_rdata = mem_m[pa[g]];
          exp_rv[g] = 1;
        end
        pq[g] = 0;
        if (lk[g]) begin
          if (owner == g) run = oreq ? run + 1 : 0;
          else            run = oreq ? 1 : 0;
          owner = g;
        end else begin
          owner = -1;
          run = 0;
        end
        prio = 1 - g;
      end else begin
        owner = -1;
        run = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
